// File: rtl/memory_arbiter_pkg.sv
// Shared widths and FSM encoding for the instruction/data memory arbiter.
package memory_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2
   } state_t;

endpackage

// File: rtl/arbiter_priority.sv
// Grant decision for the shared memory port: data wins ties until it has
// starved a waiting fetch DATA_STREAK_MAX times in a row.
module arbiter_priority
   import memory_arbiter_pkg::*;
#(
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_idle,
   input  logic i_fetch_req,
   input  logic i_data_req,
   output logic o_grant_fetch,
   output logic o_grant_data
);

   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(DATA_STREAK_MAX);

   logic [CNT_W-1:0] r_streak;
   logic             w_fetch_due;

   assign w_fetch_due   = (r_streak == STREAK_MAX);
   assign o_grant_data  = i_idle && i_data_req && !(i_fetch_req && w_fetch_due);
   assign o_grant_fetch = i_idle && i_fetch_req && !o_grant_data;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_streak <= '0;
      end else if (o_grant_fetch) begin
         r_streak <= '0;
      end else if (o_grant_data) begin
         if (!i_fetch_req)
            r_streak <= '0;
         else if (!w_fetch_due)
            r_streak <= r_streak + 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of a single-port memory
// with a fixed WAIT_CYCLES access time; all memory strobes are registered.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES     = 1,
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetchReq,
   input  logic [ADDR_W-1:0] fetchAddress,
   output logic [DATA_W-1:0] fetchData,
   output logic              fetchValid,
   input  logic              dataReq,
   input  logic              dataWrite,
   input  logic [ADDR_W-1:0] dataAddress,
   input  logic [DATA_W-1:0] dataWriteData,
   output logic [DATA_W-1:0] dataReadData,
   output logic              dataValid,
   output logic [ADDR_W-1:0] memAddress,
   output logic              memReadEnable,
   output logic              memWriteEnable,
   output logic [DATA_W-1:0] memDataIn,
   input  logic [DATA_W-1:0] memDataOut
);

   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WAIT_CYCLES - 1);
   localparam logic             SINGLE   = (WAIT_CYCLES == 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_write;
   logic [DATA_W-1:0] r_fetch_data;
   logic [DATA_W-1:0] r_data_rdata;
   logic              r_fetch_valid;
   logic              r_data_valid;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_re;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_din;

   logic w_idle;
   logic w_grant_fetch;
   logic w_grant_data;

   assign w_idle = (r_state == ST_IDLE);

   arbiter_priority #(
      .DATA_STREAK_MAX (DATA_STREAK_MAX)
   ) u_priority (
      .clk           (clk),
      .reset         (reset),
      .i_idle        (w_idle),
      .i_fetch_req   (fetchReq),
      .i_data_req    (dataReq),
      .o_grant_fetch (w_grant_fetch),
      .o_grant_data  (w_grant_data)
   );

   // Strobes are computed one edge early so they line up with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_is_write    <= 1'b0;
         r_fetch_data  <= '0;
         r_data_rdata  <= '0;
         r_fetch_valid <= 1'b0;
         r_data_valid  <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_re      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_din     <= '0;
      end else begin
         r_fetch_valid <= 1'b0;
         r_data_valid  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_data) begin
                  r_state    <= ST_DATA;
                  r_cnt      <= LOAD_CNT;
                  r_is_write <= dataWrite;
                  r_mem_addr <= dataAddress;
                  r_mem_re   <= !dataWrite;
                  r_mem_we   <= dataWrite && SINGLE;
                  r_mem_din  <= dataWrite ? dataWriteData : '0;
               end else if (w_grant_fetch) begin
                  r_state    <= ST_FETCH;
                  r_cnt      <= LOAD_CNT;
                  r_is_write <= 1'b0;
                  r_mem_addr <= fetchAddress;
                  r_mem_re   <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_din  <= '0;
               end
            end
            ST_FETCH, ST_DATA: begin
               if (r_cnt == '0) begin
                  if (r_state == ST_FETCH) begin
                     r_fetch_data  <= memDataOut;
                     r_fetch_valid <= 1'b1;
                  end else begin
                     if (!r_is_write)
                        r_data_rdata <= memDataOut;
                     r_data_valid <= 1'b1;
                  end
                  r_state    <= ST_IDLE;
                  r_mem_addr <= '0;
                  r_mem_re   <= 1'b0;
                  r_mem_we   <= 1'b0;
                  r_mem_din  <= '0;
               end else begin
                  r_cnt    <= r_cnt - 1'b1;
                  r_mem_we <= r_is_write && (r_cnt == CNT_W'(1));
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fetchData      = r_fetch_data;
   assign fetchValid     = r_fetch_valid;
   assign dataReadData   = r_data_rdata;
   assign dataValid      = r_data_valid;
   assign memAddress     = r_mem_addr;
   assign memReadEnable  = r_mem_re;
   assign memWriteEnable = r_mem_we;
   assign memDataIn      = r_mem_din;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench: instance A runs WAIT_CYCLES=1, instance B runs WAIT_CYCLES=3.
module tb_memory_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        a_reset, a_fetch_req, a_fetch_valid, a_data_req, a_data_write, a_data_valid;
   logic        a_mem_re, a_mem_we;
   logic [31:0] a_fetch_addr, a_fetch_data, a_data_addr, a_data_wdata, a_data_rdata;
   logic [31:0] a_mem_addr, a_mem_din, a_mem_dout;

   logic        b_reset, b_fetch_req, b_fetch_valid, b_data_req, b_data_write, b_data_valid;
   logic        b_mem_re, b_mem_we;
   logic [31:0] b_fetch_addr, b_fetch_data, b_data_addr, b_data_wdata, b_data_rdata;
   logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;

   memory_arbiter #(.WAIT_CYCLES(1), .DATA_STREAK_MAX(4)) dut_a (
      .clk(clk), .reset(a_reset),
      .fetchReq(a_fetch_req), .fetchAddress(a_fetch_addr),
      .fetchData(a_fetch_data), .fetchValid(a_fetch_valid),
      .dataReq(a_data_req), .dataWrite(a_data_write), .dataAddress(a_data_addr),
      .dataWriteData(a_data_wdata), .dataReadData(a_data_rdata), .dataValid(a_data_valid),
      .memAddress(a_mem_addr), .memReadEnable(a_mem_re), .memWriteEnable(a_mem_we),
      .memDataIn(a_mem_din), .memDataOut(a_mem_dout)
   );

   memory_arbiter #(.WAIT_CYCLES(3), .DATA_STREAK_MAX(4)) dut_b (
      .clk(clk), .reset(b_reset),
      .fetchReq(b_fetch_req), .fetchAddress(b_fetch_addr),
      .fetchData(b_fetch_data), .fetchValid(b_fetch_valid),
      .dataReq(b_data_req), .dataWrite(b_data_write), .dataAddress(b_data_addr),
      .dataWriteData(b_data_wdata), .dataReadData(b_data_rdata), .dataValid(b_data_valid),
      .memAddress(b_mem_addr), .memReadEnable(b_mem_re), .memWriteEnable(b_mem_we),
      .memDataIn(b_mem_din), .memDataOut(b_mem_dout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int   lat;
      logic seen;
      logic exp_f;

      a_reset = 1'b1; a_fetch_req = 1'b0; a_data_req = 1'b0; a_data_write = 1'b0;
      a_fetch_addr = '0; a_data_addr = '0; a_data_wdata = '0; a_mem_dout = '0;
      b_reset = 1'b1; b_fetch_req = 1'b0; b_data_req = 1'b0; b_data_write = 1'b0;
      b_fetch_addr = '0; b_data_addr = '0; b_data_wdata = '0; b_mem_dout = '0;

      #1;
      check("rst_fetch_valid", 32'(a_fetch_valid), 0);
      check("rst_data_valid",  32'(a_data_valid), 0);
      check("rst_fetch_data",  a_fetch_data, 0);
      check("rst_data_rdata",  a_data_rdata, 0);
      check("rst_mem_re",      32'(a_mem_re), 0);
      check("rst_mem_we",      32'(a_mem_we), 0);
      check("rst_mem_addr",    a_mem_addr, 0);
      check("rst_mem_din",     a_mem_din, 0);

      tick(); tick();
      a_reset = 1'b0; b_reset = 1'b0;

      // Single fetch, WAIT_CYCLES=1: valid two cycles after the request
      a_fetch_addr = 32'h10; a_mem_dout = 32'hDEADBEEF; a_fetch_req = 1'b1;
      tick();
      check("fetch_addr",        a_mem_addr, 32'h10);
      check("fetch_re",          32'(a_mem_re), 1);
      check("fetch_we",          32'(a_mem_we), 0);
      check("fetch_valid_early", 32'(a_fetch_valid), 0);
      tick();
      check("fetch_valid",  32'(a_fetch_valid), 1);
      check("fetch_data",   a_fetch_data, 32'hDEADBEEF);
      check("fetch_re_off", 32'(a_mem_re), 0);
      a_fetch_req = 1'b0;
      tick();
      check("fetch_valid_pulse", 32'(a_fetch_valid), 0);
      check("idle_addr",         a_mem_addr, 0);

      // Load leaves fetchData untouched
      a_data_addr = 32'h404; a_data_write = 1'b0; a_mem_dout = 32'hCAFEF00D; a_data_req = 1'b1;
      tick();
      check("load_addr", a_mem_addr, 32'h404);
      check("load_re",   32'(a_mem_re), 1);
      check("load_we",   32'(a_mem_we), 0);
      tick();
      check("load_valid",      32'(a_data_valid), 1);
      check("load_rdata",      a_data_rdata, 32'hCAFEF00D);
      check("load_fetch_hold", a_fetch_data, 32'hDEADBEEF);
      check("load_no_fvalid",  32'(a_fetch_valid), 0);
      a_data_req = 1'b0;
      tick();
      check("load_valid_pulse", 32'(a_data_valid), 0);

      // Simultaneous requests from idle: data first, fetch right after
      a_fetch_addr = 32'h20; a_data_addr = 32'h30; a_mem_dout = 32'h11111111;
      a_fetch_req = 1'b1; a_data_req = 1'b1;
      tick();
      check("sim_first_data", a_mem_addr, 32'h30);
      tick();
      check("sim_data_valid", 32'(a_data_valid), 1);
      check("sim_data_rdata", a_data_rdata, 32'h11111111);
      a_data_req = 1'b0; a_mem_dout = 32'h22222222;
      tick();
      check("sim_then_fetch", a_mem_addr, 32'h20);
      check("sim_fetch_re",   32'(a_mem_re), 1);
      tick();
      check("sim_fetch_valid", 32'(a_fetch_valid), 1);
      check("sim_fetch_data",  a_fetch_data, 32'h22222222);
      a_fetch_req = 1'b0;
      tick();

      // Both held: D,D,D,D,F,D,D,D,D,F
      a_fetch_req = 1'b1; a_data_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_f = ((i % 5) == 4);
         tick();
         check($sformatf("streak_addr_%0d", i), a_mem_addr, exp_f ? 32'h20 : 32'h30);
         tick();
         check($sformatf("streak_valid_%0d", i), 32'({a_fetch_valid, a_data_valid}),
               exp_f ? 32'h2 : 32'h1);
      end
      a_fetch_req = 1'b0; a_data_req = 1'b0;
      tick();

      // Store, WAIT_CYCLES=3: one write strobe in the third access cycle
      b_data_addr = 32'h400; b_data_wdata = 32'h12345678; b_data_write = 1'b1; b_data_req = 1'b1;
      tick();
      check("store_c1_we",   32'(b_mem_we), 0);
      check("store_c1_addr", b_mem_addr, 32'h400);
      check("store_c1_din",  b_mem_din, 32'h12345678);
      check("store_c1_re",   32'(b_mem_re), 0);
      tick();
      check("store_c2_we",    32'(b_mem_we), 0);
      check("store_c2_valid", 32'(b_data_valid), 0);
      tick();
      check("store_c3_we",    32'(b_mem_we), 1);
      check("store_c3_valid", 32'(b_data_valid), 0);
      tick();
      check("store_c4_we",    32'(b_mem_we), 0);
      check("store_c4_valid", 32'(b_data_valid), 1);
      check("store_rdata",    b_data_rdata, 0);
      b_data_req = 1'b0;
      tick();
      check("store_valid_pulse", 32'(b_data_valid), 0);

      // Fetch request dropped after grant still completes
      b_fetch_addr = 32'h40; b_mem_dout = 32'h5A5A5A5A; b_fetch_req = 1'b1;
      tick();
      b_fetch_req = 1'b0;
      check("drop_addr", b_mem_addr, 32'h40);
      check("drop_re",   32'(b_mem_re), 1);
      lat = 0;
      for (int c = 2; c <= 8 && lat == 0; c++) begin
         tick();
         if (b_fetch_valid) lat = c;
      end
      check("drop_latency", 32'(lat), 4);
      check("drop_data",    b_fetch_data, 32'h5A5A5A5A);
      tick();

      // Reset in the second cycle of a store aborts it
      b_data_addr = 32'h500; b_data_wdata = 32'hAAAA5555; b_data_write = 1'b1; b_data_req = 1'b1;
      tick();
      check("abort_c1_addr", b_mem_addr, 32'h500);
      tick();
      b_reset = 1'b1; b_data_req = 1'b0;
      #1;
      check("abort_we",         32'(b_mem_we), 0);
      check("abort_re",         32'(b_mem_re), 0);
      check("abort_addr",       b_mem_addr, 0);
      check("abort_din",        b_mem_din, 0);
      check("abort_fetch_data", b_fetch_data, 0);
      check("abort_data_valid", 32'(b_data_valid), 0);
      #2;
      b_reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         seen = seen | b_mem_we | b_mem_re | b_data_valid;
      end
      check("abort_quiet", 32'(seen), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: memory access cycles per transaction (1..15).
REQ-002 Parameter DATA_STREAK_MAX, default 4: consecutive data grants allowed while fetch waits (1..15).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetchReq  input  1  instruction-fetch request; held with fetchAddress stable until fetchValid.
REQ-006 fetchAddress  input  32  fetch word address.
REQ-007 fetchData  output  32  registered fetch read data.
REQ-008 fetchValid  output  1  one-cycle pulse: fetch complete, fetchData valid.
REQ-009 dataReq  input  1  load/store request; held with address, write flag and write data stable until dataValid.
REQ-010 dataWrite  input  1  1 = store, 0 = load.
REQ-011 dataAddress  input  32  load/store address.
REQ-012 dataWriteData  input  32  store data.
REQ-013 dataReadData  output  32  registered load data.
REQ-014 dataValid  output  1  one-cycle pulse: load/store complete.
REQ-015 memAddress  output  32  address to shared memory.
REQ-016 memReadEnable  output  1  read strobe to shared memory.
REQ-017 memWriteEnable  output  1  write strobe to shared memory.
REQ-018 memDataIn  output  32  write data to shared memory.
REQ-019 memDataOut  input  32  read data from shared memory.

Function
REQ-020 FSM states IDLE, FETCH, DATA; only one requester drives memory at a time.
REQ-021 IDLE: no request -> stay IDLE; grant decided combinationally from requests, state changes next edge.
REQ-022 Grant rule: dataReq alone -> DATA; fetchReq alone -> FETCH; both -> DATA unless streak counter equals DATA_STREAK_MAX, then FETCH.
REQ-023 Streak counter: +1 per DATA grant made while fetchReq high; cleared on any FETCH grant or any DATA grant with fetchReq low; saturates at DATA_STREAK_MAX.
REQ-024 FETCH/DATA: access counter loads WAIT_CYCLES-1 on entry, decrements each cycle; access ends in cycle where counter is 0.
REQ-025 During FETCH: memAddress=fetchAddress, memReadEnable=1, memWriteEnable=0.
REQ-026 During DATA load: memAddress=dataAddress, memReadEnable=1, memWriteEnable=0.
REQ-027 During DATA store: memAddress=dataAddress, memDataIn=dataWriteData, memReadEnable=0, memWriteEnable=1 only in final access cycle (exactly one write edge).
REQ-028 In IDLE: memReadEnable=0, memWriteEnable=0, memAddress=0, memDataIn=0.
REQ-029 Final access cycle: memDataOut captured into fetchData (FETCH) or dataReadData (DATA load) at that edge; FSM returns to IDLE.
REQ-030 Valid pulse asserted the cycle after final access cycle (coincides with IDLE), exactly one cycle; store also pulses dataValid, dataReadData unchanged.
REQ-031 Latency request-to-valid with idle arbiter: WAIT_CYCLES+1 cycles; peak throughput one transaction per WAIT_CYCLES+1 cycles.
REQ-032 Requester dropping req mid-access: access still completes and valid pulses; requester must ignore it.
REQ-033 fetchData/dataReadData hold last value until next capture.

Reset
REQ-034 reset asserted: immediately state=IDLE, both counters 0, fetchValid=0, dataValid=0, fetchData=0, dataReadData=0, all mem strobes 0.
REQ-035 Reset mid-access aborts transaction: no valid pulse; store in progress issues no write if reset precedes final cycle.

Structure
REQ-036 State encoding and width constants (address 32, data 32, counter 4) in shared package memory_arbiter_pkg.
REQ-037 Single sub-module natural: arbiter_priority (combinational grant + streak counter); FSM and datapath in memory_arbiter.

Verification
REQ-038 WAIT_CYCLES=1, fetchReq addr 0x10, memDataOut=0xDEADBEEF -> fetchValid cycle 2, fetchData=0xDEADBEEF.
REQ-039 Store addr 0x400 data 0x12345678, WAIT_CYCLES=3 -> memWriteEnable high exactly one cycle (third access cycle), dataValid one cycle later.
REQ-040 Both requests held continuously, DATA_STREAK_MAX=4 -> grant sequence D,D,D,D,F repeating.
REQ-041 Simultaneous request from idle, streak 0 -> DATA first, FETCH immediately after.
REQ-042 reset pulsed during second cycle of WAIT_CYCLES=3 store -> no write strobe, no dataValid, all outputs zero, IDLE.
REQ-043 Load addr 0x404 returning 0xCAFEF00D -> dataValid, dataReadData=0xCAFEF00D, fetchData unchanged.
